sched_timing_adapter_fifo: RTL and testbench
============================================

SCHED_TIMING_ADAPTER_FIFO -- requirements
Module: sched_timing_adapter_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2, payload bit width (1..512).
REQ-002 SHALL have parameter IN_READY_LATENCY, default 0, upstream Avalon-ST ready latency in cycles (0..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, buffer entries, power of 2, legal only if FIFO_DEPTH >= IN_READY_LATENCY+2.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-007 SHALL have port in_valid  input  1  upstream beat qualifier.
REQ-008 SHALL have port in_ready  output  1  upstream backpressure, interpreted with IN_READY_LATENCY.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  downstream payload.
REQ-010 SHALL have port out_valid  output  1  downstream beat qualifier, ready latency 0.
REQ-011 SHALL have port out_ready  input  1  downstream backpressure.
REQ-012 SHALL have port clear_overflow  input  1  clears sticky overflow flag.
REQ-013 SHALL have port overflow  output  1  sticky flag, beat dropped.
REQ-014 SHALL have port fill_level  output  log2(FIFO_DEPTH)+1  current entry count.

Function
REQ-015 SHALL implement a show-ahead circular buffer of FIFO_DEPTH entries with write pointer, read pointer and count registers.
REQ-016 Push SHALL occur when in_valid=1 and (count < FIFO_DEPTH or pop in same cycle); in_data written at wr_ptr, wr_ptr increments modulo FIFO_DEPTH.
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1; rd_ptr increments modulo FIFO_DEPTH.
REQ-018 count SHALL be +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds FIFO_DEPTH, never below 0.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL equal entry at rd_ptr when out_valid=1, all-zero when out_valid=0.
REQ-020 Write-to-output latency SHALL be 1 cycle: beat pushed in cycle t into an empty buffer appears on out_valid/out_data in cycle t+1.
REQ-021 in_ready SHALL be 1 iff count <= FIFO_DEPTH-IN_READY_LATENCY-1 (combinational from registered count only, no path from in_valid or out_ready).
REQ-022 With this threshold, an upstream that honours IN_READY_LATENCY SHALL never cause a drop.
REQ-023 in_valid=1 with count=FIFO_DEPTH and no same-cycle pop SHALL discard the beat, leave pointers/count unchanged, and set overflow next cycle.
REQ-024 overflow SHALL stay 1 until a cycle with clear_overflow=1; if a drop and clear_overflow coincide, overflow SHALL be 1 after that cycle (set wins).
REQ-025 fill_level SHALL equal count.
REQ-026 Ordering SHALL be strict FIFO; no beat duplicated or reordered.
REQ-027 out_valid, once 1, SHALL remain 1 with stable out_data until popped (Avalon-ST hold rule).

Reset
REQ-028 While reset=1 at a rising edge: count, wr_ptr, rd_ptr, overflow SHALL clear to 0; buffer storage need not be cleared.
REQ-029 During and after reset: out_valid=0, out_data=0, fill_level=0, overflow=0; in_ready SHALL be forced 0 while reset=1 and follow REQ-021 from the first cycle after.
REQ-030 Reset mid-transfer SHALL discard all buffered beats; push/pop in the reset cycle SHALL be ignored.

Verification
REQ-031 Defaults, single beat: push 2'b10 into empty buffer -> next cycle out_valid=1, out_data=2'b10, fill_level=1; pop -> out_valid=0, out_data=0.
REQ-032 IN_READY_LATENCY=2, FIFO_DEPTH=8, out_ready=0, upstream obeys latency -> in_ready falls when count reaches 6, exactly 8 beats stored, overflow stays 0.
REQ-033 Defaults, fill to 8 with out_ready=0, then in_valid=1 -> beat dropped, count stays 8, overflow=1 next cycle; clear_overflow pulse -> overflow=0.
REQ-034 Full buffer, simultaneous push and pop -> push accepted, count stays 8, output order preserved, overflow stays 0.
REQ-035 Random in_valid/out_ready 10,000 cycles, DATA_WIDTH=32 -> scoreboard shows no loss, no reorder, fill_level matches model every cycle.
REQ-036 Reset asserted with count=5 -> next cycle count=0, out_valid=0, overflow=0; in_ready=0 during reset, 1 after.

Source files
------------

// File: rtl/sched_timing_adapter_fifo.sv
// Show-ahead FIFO that adapts an upstream Avalon-ST link with nonzero ready
// latency to a zero-latency downstream link. in_ready is issued early enough
// that beats already in flight when it drops always find room. A sticky
// overflow flag records any beat that arrives while the buffer is full.
module sched_timing_adapter_fifo #(
  parameter int DATA_WIDTH       = 2,
  parameter int IN_READY_LATENCY = 0,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          clear_overflow,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Highest count at which upstream may still be told ready: the beats it
  // can launch before seeing ready fall must all fit.
  localparam int TH = FIFO_DEPTH - IN_READY_LATENCY - 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] TH_C    = TH[AW:0];

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  full, push, pop, drop;

  assign out_valid  = (count != '0);
  assign full       = (count == DEPTH_C);
  assign pop        = out_valid & out_ready;
  // A full buffer still accepts a beat when an entry leaves in the same cycle.
  assign push       = in_valid & (~full | pop);
  assign drop       = in_valid & full & ~pop;
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign in_ready   = ~reset & (count <= TH_C);
  assign fill_level = count;

  // Payload storage; left uninitialised on reset since count gates the output.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= in_data;
  end

  // Pointers and occupancy; reset wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_sched_timing_adapter_fifo.sv
// Bench for sched_timing_adapter_fifo: a default instance and a 32-bit,
// ready-latency-2 instance share one stimulus stream. A queue model tracks the
// expected contents; every mid-cycle both instances are compared against it.
module tb_sched_timing_adapter_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;

  logic        def_in_ready, def_out_valid, def_overflow;
  logic [1:0]  def_out_data;
  logic [3:0]  def_fill;
  logic        lat_in_ready, lat_out_valid, lat_overflow;
  logic [31:0] lat_out_data;
  logic [3:0]  lat_fill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sched_timing_adapter_fifo u_def (
    .clk(clk), .reset(reset), .in_data(in_data[1:0]), .in_valid(in_valid),
    .in_ready(def_in_ready), .out_data(def_out_data), .out_valid(def_out_valid),
    .out_ready(out_ready), .clear_overflow(clear_overflow),
    .overflow(def_overflow), .fill_level(def_fill));

  sched_timing_adapter_fifo #(.DATA_WIDTH(32), .IN_READY_LATENCY(2), .FIFO_DEPTH(8)) u_lat (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(lat_in_ready), .out_data(lat_out_data), .out_valid(lat_out_valid),
    .out_ready(out_ready), .clear_overflow(clear_overflow),
    .overflow(lat_overflow), .fill_level(lat_fill));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of accepted beats plus the sticky flag.
  logic [31:0] q[$];
  bit          m_ovf = 1'b0;
  bit          armed = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      armed = 1'b1;
      if (reset) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        bit do_pop, was_full;
        do_pop   = (q.size() != 0) && out_ready;
        was_full = (q.size() == 8);
        if (do_pop) void'(q.pop_front());
        if (in_valid && (!was_full || do_pop)) q.push_back(in_data);
        if (in_valid && was_full && !do_pop) m_ovf = 1'b1;
        else if (clear_overflow)             m_ovf = 1'b0;
      end
    end
  end

  // Mid-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        logic [31:0] ed;
        int sz;
        sz = q.size();
        ed = (sz != 0) ? q[0] : 32'h0;
        chk("def_valid", def_out_valid, sz != 0);
        chk("def_data",  def_out_data,  ed & 32'h3);
        chk("def_fill",  def_fill,      sz);
        chk("def_ovf",   def_overflow,  m_ovf);
        chk("def_ready", def_in_ready,  !reset && sz <= 7);
        chk("lat_valid", lat_out_valid, sz != 0);
        chk("lat_data",  lat_out_data,  ed);
        chk("lat_fill",  lat_fill,      sz);
        chk("lat_ovf",   lat_overflow,  m_ovf);
        chk("lat_ready", lat_in_ready,  !reset && sz <= 5);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); cyc(2);
    reset = 1'b0;
  endtask

  // Upstream that honours a 2-cycle ready latency of the lat instance.
  task automatic drive_lat(input int n, input bit rnd);
    bit r1, r2, cur;
    r1 = 1'b0; r2 = 1'b0;
    for (int i = 0; i < n; i++) begin
      cur       = lat_in_ready;
      in_valid  = r2 && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data   = $urandom;
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
      cyc();
      r2 = r1; r1 = cur;
    end
    idle();
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_ready_def", def_in_ready, 0);
    chk("rst_ready_lat", lat_in_ready, 0);
    chk("rst_fill", lat_fill, 0);
    reset = 1'b0;
    cyc();
    chk("post_rst_ready", lat_in_ready, 1);

    // Single beat through an empty buffer
    in_valid = 1'b1; in_data = 32'h2; cyc();
    idle();
    chk("single_valid", def_out_valid, 1);
    chk("single_data", def_out_data, 2'b10);
    chk("single_fill", def_fill, 1);
    out_ready = 1'b1; cyc();
    idle();
    chk("single_pop_valid", def_out_valid, 0);
    chk("single_pop_data", def_out_data, 0);

    // Fill to 8, then overflow
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i; cyc();
    end
    chk("full_fill", lat_fill, 8);
    chk("full_ready_def", def_in_ready, 0);
    in_data = 32'h55; cyc();
    idle();
    chk("drop_fill", lat_fill, 8);
    chk("drop_ovf", def_overflow, 1);
    chk("drop_head", lat_out_data, 1);
    clear_overflow = 1'b1; cyc();
    idle();
    chk("clear_ovf", def_overflow, 0);
    in_valid = 1'b1; clear_overflow = 1'b1; cyc();
    idle();
    chk("set_wins", lat_overflow, 1);
    clear_overflow = 1'b1; cyc();
    idle();
    chk("clear_again", lat_overflow, 0);

    // Full buffer with simultaneous push and pop
    in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b1; cyc();
    idle();
    chk("pp_fill", lat_fill, 8);
    chk("pp_head", lat_out_data, 2);
    chk("pp_ovf", lat_overflow, 0);
    out_ready = 1'b1; cyc(7);
    chk("pp_tail", lat_out_data, 32'hAA);
    cyc();
    idle();
    chk("drained", lat_fill, 0);

    // Reset with count=5 and overflow set
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i; cyc();
    end
    idle();
    out_ready = 1'b1; cyc(3);
    chk("pre_rst_fill", lat_fill, 5);
    chk("pre_rst_ovf", lat_overflow, 1);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; cyc();
    chk("mid_rst_fill", lat_fill, 0);
    chk("mid_rst_valid", lat_out_valid, 0);
    chk("mid_rst_ovf", def_overflow, 0);
    chk("mid_rst_ready", lat_in_ready, 0);
    reset = 1'b0; idle(); cyc();
    chk("after_rst_ready", lat_in_ready, 1);
    chk("after_rst_fill", def_fill, 0);

    // Latency-2 upstream into a stalled sink
    drive_lat(20, 1'b0);
    chk("lat_stored", lat_fill, 8);
    chk("lat_no_ovf", lat_overflow, 0);
    chk("lat_ready_low", lat_in_ready, 0);

    // Random traffic ignoring in_ready, drops allowed
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      in_data        = $urandom;
      out_ready      = ($urandom_range(0, 2) != 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle();

    // Random traffic honouring ready latency: no drop may occur
    do_reset();
    drive_lat(5000, 1'b1);
    chk("rand_lat_no_ovf", lat_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
